// File: rtl/prim_sync_req_pkg.sv
// Shared types and constants for the source end of the req/ack handshake.
package prim_sync_req_pkg;

    // Handshake state; 2'b11 is never produced and is treated as IDLE.
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        REQ     = 2'b01,
        ACK_LOW = 2'b10
    } sync_req_state_e;

    // Number of flops in the ack synchronizer.
    localparam int unsigned SyncDepth = 2;

endpackage

// File: rtl/prim_flop_2sync.sv
// Multi-flop synchronizer for a signal arriving from another clock domain.
module prim_flop_2sync
    import prim_sync_req_pkg::*;
#(
    parameter int unsigned         Width      = 16,
    parameter logic [Width-1:0]    ResetValue = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] stages [SyncDepth];

    // Shift the asynchronous input through the synchronizer chain.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < SyncDepth; i++) begin
                stages[i] <= ResetValue;
            end
        end else begin
            stages[0] <= d_i;
            for (int unsigned i = 1; i < SyncDepth; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign q_o = stages[SyncDepth-1];

endmodule

// File: rtl/prim_sync_req_src.sv
// Source end of a 4-phase req/ack CDC handshake: captures one word from a
// valid/ready producer, holds it on data_o and runs req up / ack up /
// req down / ack down before accepting the next word.
module prim_sync_req_src
    import prim_sync_req_pkg::*;
#(
    parameter int unsigned      Width         = 16,
    parameter logic [Width-1:0] ResetValue    = '0,
    parameter int unsigned      TimeoutCycles = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [Width-1:0] data_i,
    output logic             req_o,
    output logic [Width-1:0] data_o,
    input  logic             ack_i,
    output logic             done_o,
    output logic             busy_o,
    output logic             timeout_o
);

    localparam int unsigned CntW =
        (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
    // Count value seen during the last allowed REQ cycle; the edge that ends
    // that cycle raises timeout_o.
    localparam logic [CntW-1:0] CntLast =
        (TimeoutCycles > 0) ? CntW'(TimeoutCycles - 1) : '0;

    sync_req_state_e  state, state_n;
    logic             req_n, done_n, timeout_n;
    logic [Width-1:0] data_n;
    logic [CntW-1:0]  count, count_n;
    logic             ack_s;

    prim_flop_2sync #(
        .Width      (1),
        .ResetValue (1'b0)
    ) u_ack_sync (
        .clk_i  (clk_i),
        .rst_ni (~rst_i),
        .d_i    (ack_i),
        .q_o    (ack_s)
    );

    // Next-state and next-output logic for the handshake.
    always_comb begin
        state_n   = IDLE;
        req_n     = 1'b0;
        done_n    = 1'b0;
        timeout_n = timeout_o;
        data_n    = data_o;
        count_n   = count;
        case (state)
            REQ: begin
                state_n = REQ;
                req_n   = 1'b1;
                count_n = (count == '1) ? count : count + 1'b1;
                if ((TimeoutCycles > 0) && (count == CntLast)) begin
                    timeout_n = 1'b1;
                end
                if (ack_s) begin
                    req_n   = 1'b0;
                    state_n = ACK_LOW;
                end
            end
            ACK_LOW: begin
                state_n = ACK_LOW;
                if (!ack_s) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
            default: begin
                // IDLE, and the unused encoding recovering into IDLE; an
                // early ack_s here is ignored.
                if (valid_i) begin
                    data_n  = data_i;
                    req_n   = 1'b1;
                    count_n = '0;
                    state_n = REQ;
                end
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            req_o     <= 1'b0;
            done_o    <= 1'b0;
            timeout_o <= 1'b0;
            count     <= '0;
            data_o    <= ResetValue;
        end else begin
            state     <= state_n;
            req_o     <= req_n;
            done_o    <= done_n;
            timeout_o <= timeout_n;
            count     <= count_n;
            data_o    <= data_n;
        end
    end

    assign ready_o = (state != REQ) && (state != ACK_LOW);
    assign busy_o  = ~ready_o;

endmodule
